// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty-control path.
// Holds the duty code width, the hold/repeat FSM states and the saturating step.
package pwm_pkg;

  localparam int unsigned DUTY_W       = 4;
  localparam int unsigned DUTY_MAX_DEF = 10;
  localparam int unsigned STEP_W       = DUTY_W + 1;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Widened by one bit so the increment cannot wrap; decrement holds at zero.
  function automatic duty_t sat_step(duty_t cur, logic up, logic dn, duty_t lim);
    logic [STEP_W-1:0] w_ext;
    w_ext = {1'b0, cur};
    if (up) begin
      w_ext = (w_ext >= {1'b0, lim}) ? {1'b0, lim} : w_ext + STEP_W'(1);
    end else if (dn) begin
      w_ext = (w_ext == '0) ? w_ext : w_ext - STEP_W'(1);
    end
    return w_ext[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button, period-boundary and committed-duty signals between the buttons,
// the PWM stage and the duty controller.
interface pwm_duty_ctrl_if;
  import pwm_pkg::*;

  logic  btn_up;
  logic  btn_dn;
  logic  period_end;
  duty_t duty;
  logic  duty_upd;
  logic  at_min;
  logic  at_max;

  modport master (
    output btn_up, btn_dn, period_end,
    input  duty, duty_upd, at_min, at_max
  );

  modport slave (
    input  btn_up, btn_dn, period_end,
    output duty, duty_upd, at_min, at_max
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for one raw button.
// The accepted level follows the synchronised level after DEB_CYCLES steady cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Any cycle where the synchronised level agrees with the accepted level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 != r_level) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Converts up/down push-buttons into a saturating duty target with auto-repeat,
// committing the target to the PWM stage only on period boundaries.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned REP_CYCLES  = 8,
  parameter int unsigned DUTY_MAX    = DUTY_MAX_DEF,
  parameter int unsigned DUTY_INIT   = 5
) (
  input logic            clk,
  input logic            reset,
  pwm_duty_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic             w_up_d;
  logic             w_dn_d;
  logic             r_up_q;
  logic             r_dn_q;
  logic             w_up_rise;
  logic             w_dn_rise;
  logic             w_held;
  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dir_up;
  logic             w_dir_nxt;
  logic             w_step_up;
  logic             w_step_dn;
  duty_t            w_target_nxt;
  duty_t            r_target;
  duty_t            r_duty;
  logic             r_duty_upd;
  logic             r_at_min;
  logic             r_at_max;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (bus.btn_up),
    .o_level (w_up_d)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (bus.btn_dn),
    .o_level (w_dn_d)
  );

  assign w_up_rise = w_up_d & ~r_up_q;
  assign w_dn_rise = w_dn_d & ~r_dn_q;
  assign w_held    = r_dir_up ? w_up_d : w_dn_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir_up <= 1'b0;
      r_up_q   <= 1'b0;
      r_dn_q   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_up <= w_dir_nxt;
      r_up_q   <= w_up_d;
      r_dn_q   <= w_dn_d;
    end
  end

  // Press/hold/repeat sequencing; only the button latched on entry can hold or release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir_up;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_up_rise && !w_dn_d) begin
          w_step_up   = 1'b1;
          w_dir_nxt   = 1'b1;
          w_state_nxt = HELD;
        end else if (w_dn_rise && !w_up_d) begin
          w_step_dn   = 1'b1;
          w_dir_nxt   = 1'b0;
          w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (!w_held) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_step_up   = r_dir_up;
          w_step_dn   = ~r_dir_up;
          w_cnt_nxt   = '0;
          w_state_nxt = REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!w_held) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(REP_CYCLES - 1)) begin
          w_step_up = r_dir_up;
          w_step_dn = ~r_dir_up;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_target_nxt = sat_step(r_target, w_step_up, w_step_dn, DUTY_W'(DUTY_MAX));

  // Commit samples the pre-step target, so a same-cycle step waits for the next boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target   <= DUTY_W'(DUTY_INIT);
      r_duty     <= DUTY_W'(DUTY_INIT);
      r_duty_upd <= 1'b0;
      r_at_min   <= (DUTY_INIT == 0);
      r_at_max   <= (DUTY_INIT == DUTY_MAX);
    end else begin
      r_target <= w_target_nxt;
      r_at_min <= (w_target_nxt == '0);
      r_at_max <= (w_target_nxt == DUTY_W'(DUTY_MAX));
      if (bus.period_end && (r_target != r_duty)) begin
        r_duty     <= r_target;
        r_duty_upd <= 1'b1;
      end else begin
        r_duty_upd <= 1'b0;
      end
    end
  end

  assign bus.duty     = r_duty;
  assign bus.duty_upd = r_duty_upd;
  assign bus.at_min   = r_at_min;
  assign bus.at_max   = r_at_max;

endmodule
